// File: rtl/vga_pkg.sv
// Shared VGA constants and pixel bundles for the draw stages.
// Holds timing constants and wall-sprite geometry.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam int WALL_W  = 128;
  localparam int WALL_H  = 64;
  localparam int ROM_LAT = 1;

  localparam logic [11:0] TRANSPARENT_KEY = 12'h0F0;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_px_t;

  typedef struct packed {
    vga_px_t px;
    logic    in_win;
  } wall_pipe_t;

endpackage

// File: rtl/draw_wall_if.sv
// VGA pixel-stream bundle: timing plus rgb.
// master drives the stream, slave consumes it.
interface draw_wall_if;

  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (
    output vcount, vsync, vblnk,
    output hcount, hsync, hblnk,
    output rgb
  );

  modport slave (
    input vcount, vsync, vblnk,
    input hcount, hsync, hblnk,
    input rgb
  );

endinterface

// File: rtl/delay.sv
// Fixed-depth shift register used to align signals
// with the sprite-ROM read latency.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] sr_q [CLK_DEL];

  // shift din through CLK_DEL register stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++)
        sr_q[i] <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < CLK_DEL; i++)
        sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[CLK_DEL-1];

endmodule

// File: rtl/draw_wall.sv
// Overlays a WALL_W x WALL_H sprite on the VGA stream.
// Macro WALL_TRANSPARENT_EN: ROM pixels equal to the key show background.
module draw_wall
  import vga_pkg::*;
#(
  parameter int WALL_W_P  = WALL_W,
  parameter int WALL_H_P  = WALL_H,
  parameter int ROM_LAT_P = ROM_LAT,
  localparam int XW = $clog2(WALL_W_P),
  localparam int YW = $clog2(WALL_H_P)
) (
  input  logic             clk,
  input  logic             rst,
  draw_wall_if.slave       in_i,
  draw_wall_if.master      out_o,
  input  logic [10:0]      wall_x,
  input  logic [10:0]      wall_y,
  input  logic             wall_en,
  output logic [YW+XW-1:0] rom_addr,
  input  logic [11:0]      rom_rgb
);

  logic [10:0] x_l_q, x_l_d;
  logic [10:0] y_l_q, y_l_d;
  logic        en_l_q, en_l_d;
  logic        vblnk_prev_q;

  wall_pipe_t       s1_q, s1_d;
  wall_pipe_t       s2;
  logic [YW+XW-1:0] addr_q, addr_d;
  vga_px_t          out_q, out_d;

  logic [11:0] hc12, vc12, xl12, yl12;
  logic        in_win;
  logic        use_rom;

  // latch position/enable on the vblnk rising edge only
  always_comb begin
    x_l_d  = x_l_q;
    y_l_d  = y_l_q;
    en_l_d = en_l_q;
    if (in_i.vblnk && !vblnk_prev_q) begin
      x_l_d  = wall_x;
      y_l_d  = wall_y;
      en_l_d = wall_en;
    end
  end

  // stage 1: window test (12-bit, no wrap) and ROM address
  always_comb begin
    hc12   = {1'b0, in_i.hcount};
    vc12   = {1'b0, in_i.vcount};
    xl12   = {1'b0, x_l_q};
    yl12   = {1'b0, y_l_q};
    in_win = en_l_q
          && (hc12 >= xl12)
          && (hc12 <  xl12 + 12'(WALL_W_P))
          && (vc12 >= yl12)
          && (vc12 <  yl12 + 12'(WALL_H_P));
    addr_d = '0;
    if (in_win)
      addr_d = {YW'(in_i.vcount - y_l_q),
                XW'(in_i.hcount - x_l_q)};
    s1_d.px.vcount = in_i.vcount;
    s1_d.px.vsync  = in_i.vsync;
    s1_d.px.vblnk  = in_i.vblnk;
    s1_d.px.hcount = in_i.hcount;
    s1_d.px.hsync  = in_i.hsync;
    s1_d.px.hblnk  = in_i.hblnk;
    s1_d.px.rgb    = in_i.rgb;
    s1_d.in_win    = in_win;
  end

  // stage 1 registers and position latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_l_q        <= '0;
      y_l_q        <= '0;
      en_l_q       <= 1'b0;
      vblnk_prev_q <= 1'b0;
      s1_q         <= '0;
      addr_q       <= '0;
    end else begin
      x_l_q        <= x_l_d;
      y_l_q        <= y_l_d;
      en_l_q       <= en_l_d;
      vblnk_prev_q <= in_i.vblnk;
      s1_q         <= s1_d;
      addr_q       <= addr_d;
    end
  end

  assign rom_addr = addr_q;

  delay #(
    .WIDTH   ($bits(wall_pipe_t)),
    .CLK_DEL (ROM_LAT_P)
  ) u_rom_align (
    .clk    (clk),
    .rst    (rst),
    .din_i  (s1_q),
    .dout_o (s2)
  );

  // stage 3: blanking, then sprite-over-background mux
  always_comb begin
`ifdef WALL_TRANSPARENT_EN
    use_rom = s2.in_win && (rom_rgb != TRANSPARENT_KEY);
`else
    use_rom = s2.in_win;
`endif
    out_d = s2.px;
    if (s2.px.hblnk || s2.px.vblnk)
      out_d.rgb = 12'h000;
    else if (use_rom)
      out_d.rgb = rom_rgb;
  end

  // stage 3 output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out_o.vcount = out_q.vcount;
  assign out_o.vsync  = out_q.vsync;
  assign out_o.vblnk  = out_q.vblnk;
  assign out_o.hcount = out_q.hcount;
  assign out_o.hsync  = out_q.hsync;
  assign out_o.hblnk  = out_q.hblnk;
  assign out_o.rgb    = out_q.rgb;

endmodule
